// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: requests cards, deals P0/D0/P1/D1, runs player and dealer turns, scores the round
// and drives eight 5-bit glyph codes. Define SOFT17_HIT_EN to make the dealer hit a soft DEALER_STAND total.
module blackjack_round_ctrl #(
    parameter int CARD_TIMEOUT = 1024,
    parameter int DEALER_STAND = 17
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        deal_btn,
    input  logic        hit_btn,
    input  logic        staylever,
    output logic        card_req,
    input  logic        card_valid,
    input  logic [3:0]  card_value,
    output logic [39:0] disp_codes,
    output logic [1:0]  result,
    output logic        round_done
);
    localparam int TW = $clog2(CARD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(CARD_TIMEOUT - 1);
    localparam logic [4:0] STAND = 5'(DEALER_STAND);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_DEAL_P0 = 4'd1;
    localparam logic [3:0] S_DEAL_D0 = 4'd2;
    localparam logic [3:0] S_DEAL_P1 = 4'd3;
    localparam logic [3:0] S_DEAL_D1 = 4'd4;
    localparam logic [3:0] S_PLAYER  = 4'd5;
    localparam logic [3:0] S_P_HIT   = 4'd6;
    localparam logic [3:0] S_DEALER  = 4'd7;
    localparam logic [3:0] S_D_HIT   = 4'd8;
    localparam logic [3:0] S_RESULT  = 4'd9;
    localparam logic [3:0] S_ERROR   = 4'd10;

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_WIN  = 2'b01;
    localparam logic [1:0] R_LOSE = 2'b10;
    localparam logic [1:0] R_PUSH = 2'b11;

    // Glyph strings, out7 in the top slot down to out0 in the bottom slot
    localparam logic [39:0] G_READY = {5'd21, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd20, 5'd20};
    localparam logic [39:0] G_WIN   = {5'd18, 5'd1,  5'd17, 5'd20, 5'd15, 5'd0,  5'd14, 5'd20};
    localparam logic [39:0] G_LOSE  = {5'd11, 5'd5,  5'd0,  5'd16, 5'd20, 5'd15, 5'd0,  5'd14};
    localparam logic [39:0] G_TIE   = {5'd11, 5'd1,  5'd19, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20};
    localparam logic [39:0] G_ERR   = {5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd10, 5'd10, 5'd11};

    logic [3:0]    state;
    logic [4:0]    p_hard, d_hard, d_first;
    logic          p_ace, d_ace;
    logic          deal_prev, hit_prev, stay_prev;
    logic [TW-1:0] tmo_cnt;

    logic          deal_ev, hit_ev, stay_ev, accept, card_state, player_card;
    logic [4:0]    card, p_hard_nx, p_best, p_best_nx, d_best;
    logic          p_ace_nx, d_draw;
    logic [1:0]    outcome;
    logic [9:0]    pd, dd;
    logic [39:0]   disp_nx;

    function automatic logic [4:0] best_of(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    // {tens glyph, ones glyph}; a zero tens digit is shown blank
    function automatic logic [9:0] two_digit(input logic [4:0] v);
        logic [4:0] t, o;
        if (v >= 5'd30)      begin t = 5'd3; o = v - 5'd30; end
        else if (v >= 5'd20) begin t = 5'd2; o = v - 5'd20; end
        else if (v >= 5'd10) begin t = 5'd1; o = v - 5'd10; end
        else                 begin t = 5'd0; o = v;         end
        return {(t == 5'd0) ? 5'd20 : t, o};
    endfunction

    always_comb begin
        deal_ev     = deal_btn & ~deal_prev;
        hit_ev      = hit_btn & ~hit_prev;
        stay_ev     = staylever & ~stay_prev;
        card        = (card_value >= 4'd1 && card_value <= 4'd10) ? {1'b0, card_value} : 5'd10;
        accept      = card_req & card_valid;
        card_state  = state inside {S_DEAL_P0, S_DEAL_D0, S_DEAL_P1, S_DEAL_D1, S_P_HIT, S_D_HIT};
        player_card = state inside {S_DEAL_P0, S_DEAL_P1, S_P_HIT};
        p_hard_nx   = p_hard + card;
        p_ace_nx    = p_ace | (card == 5'd1);
        p_best      = best_of(p_hard, p_ace);
        p_best_nx   = best_of(p_hard_nx, p_ace_nx);
        d_best      = best_of(d_hard, d_ace);
        d_draw      = d_best < STAND;
`ifdef SOFT17_HIT_EN
        if (d_best == STAND && d_ace && d_hard <= 5'd11) d_draw = 1'b1;
`endif
        if (p_hard > 5'd21)       outcome = R_LOSE;
        else if (d_hard > 5'd21)  outcome = R_WIN;
        else if (p_best > d_best) outcome = R_WIN;
        else if (p_best == d_best) outcome = R_PUSH;
        else                      outcome = R_LOSE;
    end

    always_comb begin
        pd      = two_digit(p_best);
        dd      = two_digit((state == S_DEALER || state == S_D_HIT) ? d_best : d_first);
        disp_nx = {8{5'd20}};
        case (state)
            S_IDLE:   disp_nx = G_READY;
            S_ERROR:  disp_nx = G_ERR;
            S_RESULT: begin
                case (result)
                    R_WIN:   disp_nx = G_WIN;
                    R_PUSH:  disp_nx = G_TIE;
                    default: disp_nx = G_LOSE;
                endcase
            end
            default: begin
                disp_nx[4:0]   = pd[9:5];
                disp_nx[9:5]   = pd[4:0];
                disp_nx[34:30] = dd[9:5];
                disp_nx[39:35] = dd[4:0];
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            card_req   <= 1'b0;
            result     <= R_NONE;
            round_done <= 1'b0;
            p_hard     <= '0;
            d_hard     <= '0;
            d_first    <= '0;
            p_ace      <= 1'b0;
            d_ace      <= 1'b0;
            deal_prev  <= 1'b0;
            hit_prev   <= 1'b0;
            stay_prev  <= 1'b0;
            tmo_cnt    <= '0;
            disp_codes <= G_READY;
        end else begin
            deal_prev  <= deal_btn;
            hit_prev   <= hit_btn;
            stay_prev  <= staylever;
            round_done <= 1'b0;
            disp_codes <= disp_nx;
            tmo_cnt    <= (card_req && !card_valid) ? tmo_cnt + 1'b1 : '0;
            if (card_state) begin
                if (accept) begin
                    card_req <= 1'b0;
                    if (player_card) begin
                        p_hard <= p_hard_nx;
                        p_ace  <= p_ace_nx;
                    end else begin
                        d_hard <= d_hard + card;
                        d_ace  <= d_ace | (card == 5'd1);
                    end
                    case (state)
                        S_DEAL_P0: state <= S_DEAL_D0;
                        S_DEAL_D0: begin state <= S_DEAL_P1; d_first <= card; end
                        S_DEAL_P1: state <= S_DEAL_D1;
                        S_DEAL_D1: state <= (p_best == 5'd21) ? S_DEALER : S_PLAYER;
                        S_P_HIT: begin
                            if (p_hard_nx > 5'd21) begin
                                state      <= S_RESULT;
                                result     <= R_LOSE;
                                round_done <= 1'b1;
                            end else if (p_best_nx == 5'd21) begin
                                state <= S_DEALER;
                            end else begin
                                state <= S_PLAYER;
                            end
                        end
                        default: state <= S_DEALER;
                    endcase
                end else if (card_req && tmo_cnt == TMO_LAST) begin
                    card_req <= 1'b0;
                    state    <= S_ERROR;
                end else begin
                    // re-arms the request after the one-cycle gap between chained deal cards
                    card_req <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE, S_RESULT, S_ERROR: begin
                        if (deal_ev) begin
                            state    <= S_DEAL_P0;
                            card_req <= 1'b1;
                            result   <= R_NONE;
                            p_hard   <= '0;
                            d_hard   <= '0;
                            d_first  <= '0;
                            p_ace    <= 1'b0;
                            d_ace    <= 1'b0;
                        end
                    end
                    S_PLAYER: begin
                        if (stay_ev) begin
                            state <= S_DEALER;
                        end else if (hit_ev) begin
                            state    <= S_P_HIT;
                            card_req <= 1'b1;
                        end
                    end
                    S_DEALER: begin
                        if (d_draw) begin
                            state    <= S_D_HIT;
                            card_req <= 1'b1;
                        end else begin
                            state      <= S_RESULT;
                            result     <= outcome;
                            round_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
